// File: rtl/sr_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider for the sr_cpu multi-cycle extension path.
// One iteration per cycle, one-cycle ready pulse, RISC-V divide-by-zero semantics.
module sr_muldiv_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             busy,
    output logic             ready,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [2:0] OP_MUL   = 3'b000;
    localparam logic [2:0] OP_MULHU = 3'b001;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_REMU  = 3'b101;

    state_t             state, stateNext;
    logic [CNT_W-1:0]   cnt;
    logic               isDiv, selHi;
    logic [WIDTH-1:0]   opA, opB;
    logic [WIDTH:0]     acc;
    logic [WIDTH-1:0]   lo;

    logic               legalOp, fastPath;
    logic [WIDTH-1:0]   fastResult;
    logic [WIDTH:0]     mulSum, divShift, divDiff;
    logic               divGe;
    logic [WIDTH:0]     accNext;
    logic [WIDTH-1:0]   loNext;

    // Acceptance decode works on the live inputs; only IDLE ever consumes it.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        legalOp    = (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
        fastPath   = !legalOp || (op[2] && (srcB == '0));
        fastResult = '0;
        if (legalOp && op[2])
            fastResult = op[0] ? srcA : '1;
    end

    // acc doubles as {carry,hi} for multiply and as the WIDTH+1 bit remainder for divide.
    always_comb begin
        mulSum   = acc + {1'b0, opA & {WIDTH{lo[0]}}};
        divShift = {acc[WIDTH-1:0], lo[WIDTH-1]};
        divDiff  = divShift - {1'b0, opB};
        divGe    = divShift >= {1'b0, opB};
        if (isDiv) begin
            accNext = divGe ? divDiff : divShift;
            loNext  = {lo[WIDTH-2:0], divGe};
        end else begin
            accNext = {1'b0, mulSum[WIDTH:1]};
            loNext  = {mulSum[0], lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (start) stateNext = fastPath ? DONE : RUN;
            RUN:     if (cnt == '0) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != IDLE);
        ready = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            isDiv  <= 1'b0;
            selHi  <= 1'b0;
            opA    <= '0;
            opB    <= '0;
            acc    <= '0;
            lo     <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    cnt   <= CNT_W'(WIDTH - 1);
                    isDiv <= op[2];
                    selHi <= op[0];
                    opA   <= srcA;
                    opB   <= srcB;
                    acc   <= '0;
                    lo    <= op[2] ? srcA : srcB;
                    if (fastPath) result <= fastResult;
                end
                RUN: begin
                    acc <= accNext;
                    lo  <= loNext;
                    // The last iteration's values go straight to result as DONE is entered.
                    if (cnt == '0) result <= selHi ? accNext[WIDTH-1:0] : loNext;
                    else           cnt    <= cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sr_muldiv_iter.sv
// Directed bench for sr_muldiv_iter: latency, arithmetic results, fast paths, reset abort, back-to-back ops.
module tb_sr_muldiv_iter;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [2:0]       op = 3'b000;
    logic [WIDTH-1:0] srcA = '0;
    logic [WIDTH-1:0] srcB = '0;
    logic             busy, ready;
    logic [WIDTH-1:0] result;

    int checks = 0;
    int failures = 0;

    sr_muldiv_iter #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .srcA(srcA), .srcB(srcB), .busy(busy), .ready(ready), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Counts cycles (sampled 1 ns after each edge) until ready; the first edge is the accepting one.
    task automatic waitReady(input bit perturb, output int n, output int busyCnt);
        n = 0;
        busyCnt = 0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (busy) busyCnt++;
            if (perturb && n == 5) begin
                srcA = 32'hDEAD_BEEF;
                srcB = 32'h0000_0003;
                op   = 3'b010;
            end
            if (ready) break;
        end
    endtask

    // Issues one op from IDLE with start held until ready, then returns with the DUT back in IDLE.
    task automatic runOp(input string tag, input logic [2:0] o, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp, input int expLat);
        int n, bc;
        op = o; srcA = a; srcB = b; start = 1'b1;
        waitReady(expLat > 1, n, bc);
        check({tag, " latency"}, n, expLat);
        check({tag, " result"}, result, exp);
        start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, bc;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", busy, 0);
        check("reset ready", ready, 0);
        check("reset result", result, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // MUL 7*6 with busy/ready timing observed.
        op = 3'b000; srcA = 7; srcB = 6; start = 1'b1;
        waitReady(1'b1, n, bc);
        check("mul7x6 latency", n, 33);
        check("mul7x6 result", result, 42);
        check("mul7x6 busy cycles", bc, 33);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("mul7x6 ready pulse width", ready, 0);
        check("mul7x6 busy after done", busy, 0);
        check("mul7x6 result held", result, 42);

        runOp("mulhu max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        runOp("mul max",   3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33);
        runOp("divu 100/7", 3'b100, 100, 7, 14, 33);
        runOp("remu 100/7", 3'b101, 100, 7, 2, 33);
        runOp("divu max/1", 3'b100, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 33);
        runOp("remu 5/9",   3'b101, 5, 9, 5, 33);
        runOp("divu by 0",  3'b100, 123, 0, 32'hFFFF_FFFF, 1);
        runOp("remu by 0",  3'b101, 123, 0, 123, 1);
        runOp("illegal op", 3'b010, 55, 11, 0, 1);
        runOp("mul 12x5",   3'b000, 12, 5, 60, 33);

        // Reset mid-MUL aborts everything immediately.
        op = 3'b000; srcA = 1000; srcB = 1000; start = 1'b1;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        check("abort busy", busy, 0);
        check("abort ready", ready, 0);
        check("abort result", result, 0);
        repeat (3) @(posedge clk);
        #2;
        check("abort ready held low", ready, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        runOp("divu 9/3 after reset", 3'b100, 9, 3, 3, 33);

        // Back-to-back with start held throughout; operands perturbed mid-run in both ops.
        op = 3'b000; srcA = 3; srcB = 3; start = 1'b1;
        waitReady(1'b1, n, bc);
        check("b2b mul latency", n, 33);
        check("b2b mul result", result, 9);
        op = 3'b100; srcA = 8; srcB = 2;
        waitReady(1'b1, n, bc);
        check("b2b spacing", n, 34);
        check("b2b divu result", result, 4);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("b2b idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
